// File: rtl/exc_word_gen_if.sv
// Exception word bus from the collector to CP0: per-lane control word, PC,
// bad virtual address, and the pipeline flush request.
interface exc_word_gen_if;
    logic [15:0] exc_word_1;
    logic [15:0] exc_word_2;
    logic [31:0] exc_pc_1;
    logic [31:0] exc_pc_2;
    logic [31:0] exc_vaddr_1;
    logic [31:0] exc_vaddr_2;
    logic        exc_flush;

    modport master (
        output exc_word_1, exc_word_2, exc_pc_1, exc_pc_2,
               exc_vaddr_1, exc_vaddr_2, exc_flush
    );

    modport slave (
        input exc_word_1, exc_word_2, exc_pc_1, exc_pc_2,
              exc_vaddr_1, exc_vaddr_2, exc_flush
    );
endinterface

// File: rtl/exc_word_gen.sv
// Dual-lane exception collector: carries ID causes through EX and MEM, merges
// EX overflow and MEM address errors, and emits one prioritised word per lane.
module exc_word_gen (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        ext_flush,
    input  logic        id_valid_1,
    input  logic        id_valid_2,
    input  logic [31:0] id_pc_1,
    input  logic [31:0] id_pc_2,
    input  logic        id_ds_1,
    input  logic        id_ds_2,
    input  logic        id_if_adel_1,
    input  logic        id_if_adel_2,
    input  logic        id_ri_1,
    input  logic        id_ri_2,
    input  logic        id_break_1,
    input  logic        id_break_2,
    input  logic        id_syscall_1,
    input  logic        id_syscall_2,
    input  logic        id_eret_1,
    input  logic        id_eret_2,
    input  logic        ex_ov_1,
    input  logic        ex_ov_2,
    input  logic        mem_adel_1,
    input  logic        mem_adel_2,
    input  logic        mem_ades_1,
    input  logic        mem_ades_2,
    input  logic [31:0] mem_vaddr_1,
    input  logic [31:0] mem_vaddr_2,
    exc_word_gen_if.master cp0
);

    logic [1:0]  id_valid, id_ds, ex_ov, mem_adel, mem_ades;
    logic [31:0] id_pc [2];
    logic [31:0] mem_vaddr [2];
    logic [7:0]  id_cause [2];

    assign id_valid  = {id_valid_2, id_valid_1};
    assign id_ds     = {id_ds_2, id_ds_1};
    assign ex_ov     = {ex_ov_2, ex_ov_1};
    assign mem_adel  = {mem_adel_2, mem_adel_1};
    assign mem_ades  = {mem_ades_2, mem_ades_1};
    assign id_pc[0]     = id_pc_1;
    assign id_pc[1]     = id_pc_2;
    assign mem_vaddr[0] = mem_vaddr_1;
    assign mem_vaddr[1] = mem_vaddr_2;

    // Cause bits: 0 IF adel, 1 RI, 2 OV, 3 break, 4 syscall, 5 MEM adel, 6 eret, 7 MEM ades.
    assign id_cause[0] = {1'b0, id_eret_1, 1'b0, id_syscall_1, id_break_1, 1'b0,
                          id_ri_1, id_if_adel_1} & {8{id_valid_1}};
    assign id_cause[1] = {1'b0, id_eret_2, 1'b0, id_syscall_2, id_break_2, 1'b0,
                          id_ri_2, id_if_adel_2} & {8{id_valid_2}};

    logic [1:0]  ex_valid_q, ex_valid_d, ex_ds_q, ex_ds_d;
    logic [1:0]  mem_valid_q, mem_valid_d, mem_ds_q, mem_ds_d;
    logic [31:0] ex_pc_q [2];
    logic [31:0] ex_pc_d [2];
    logic [31:0] mem_pc_q [2];
    logic [31:0] mem_pc_d [2];
    logic [7:0]  ex_cause_q [2];
    logic [7:0]  ex_cause_d [2];
    logic [7:0]  mem_cause_q [2];
    logic [7:0]  mem_cause_d [2];

    logic [7:0]  mem_raw [2];
    logic [7:0]  cause [2];
    logic [15:0] word [2];
    logic [31:0] pc_out [2];
    logic [31:0] vaddr [2];
    logic        flush_exc, flush_all;

    function automatic logic [7:0] prio_pick(input logic [7:0] r);
        logic [7:0] p;
        p = 8'h00;
        if      (r[0]) p = 8'h01;
        else if (r[1]) p = 8'h02;
        else if (r[3]) p = 8'h08;
        else if (r[4]) p = 8'h10;
        else if (r[6]) p = 8'h40;
        else if (r[2]) p = 8'h04;
        else if (r[5]) p = 8'h20;
        else if (r[7]) p = 8'h80;
        return p;
    endfunction

    always_comb begin
        for (int l = 0; l < 2; l++) begin
            mem_raw[l] = (mem_cause_q[l] | {mem_ades[l], 1'b0, mem_adel[l], 5'b0})
                         & {8{mem_valid_q[l]}};
            cause[l]   = prio_pick(mem_raw[l]);
            word[l]    = {|cause[l], 6'b0, mem_ds_q[l] & (|cause[l]), cause[l]};
            pc_out[l]  = mem_valid_q[l] ? mem_pc_q[l] : 32'h0;
            if (cause[l][5] | cause[l][7]) begin
                vaddr[l] = mem_vaddr[l];
            end else if (cause[l][0]) begin
                vaddr[l] = mem_pc_q[l];
            end else begin
                vaddr[l] = 32'h0;
            end
        end
    end

    // Lane 1 is older, so its exception masks whatever lane 2 reports.
    assign cp0.exc_word_1  = word[0];
    assign cp0.exc_word_2  = word[0][15] ? 16'h0000 : word[1];
    assign cp0.exc_pc_1    = pc_out[0];
    assign cp0.exc_pc_2    = pc_out[1];
    assign cp0.exc_vaddr_1 = vaddr[0];
    assign cp0.exc_vaddr_2 = vaddr[1];
    assign flush_exc       = word[0][15] | word[1][15];
    assign cp0.exc_flush   = flush_exc;
    assign flush_all       = flush_exc | ext_flush;

    // Any flush empties both stages, which also covers the lane-2 case where
    // EX lane 1 is younger than the faulting MEM lane 2. Flush beats stall.
    always_comb begin
        ex_valid_d  = ex_valid_q;
        ex_ds_d     = ex_ds_q;
        ex_pc_d     = ex_pc_q;
        ex_cause_d  = ex_cause_q;
        mem_valid_d = mem_valid_q;
        mem_ds_d    = mem_ds_q;
        mem_pc_d    = mem_pc_q;
        mem_cause_d = mem_cause_q;
        if (flush_all) begin
            ex_valid_d  = 2'b00;
            mem_valid_d = 2'b00;
            for (int l = 0; l < 2; l++) begin
                ex_cause_d[l]  = 8'h00;
                mem_cause_d[l] = 8'h00;
            end
        end else if (!stall) begin
            for (int l = 0; l < 2; l++) begin
                ex_valid_d[l]  = id_valid[l];
                ex_ds_d[l]     = id_ds[l];
                ex_pc_d[l]     = id_pc[l];
                ex_cause_d[l]  = id_cause[l];
                mem_valid_d[l] = ex_valid_q[l];
                mem_ds_d[l]    = ex_ds_q[l];
                mem_pc_d[l]    = ex_pc_q[l];
                mem_cause_d[l] = ex_cause_q[l] | ({5'b0, ex_ov[l], 2'b0} & {8{ex_valid_q[l]}});
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid_q  <= 2'b00;
            ex_ds_q     <= 2'b00;
            mem_valid_q <= 2'b00;
            mem_ds_q    <= 2'b00;
            for (int l = 0; l < 2; l++) begin
                ex_pc_q[l]     <= 32'h0;
                ex_cause_q[l]  <= 8'h00;
                mem_pc_q[l]    <= 32'h0;
                mem_cause_q[l] <= 8'h00;
            end
        end else begin
            ex_valid_q  <= ex_valid_d;
            ex_ds_q     <= ex_ds_d;
            mem_valid_q <= mem_valid_d;
            mem_ds_q    <= mem_ds_d;
            for (int l = 0; l < 2; l++) begin
                ex_pc_q[l]     <= ex_pc_d[l];
                ex_cause_q[l]  <= ex_cause_d[l];
                mem_pc_q[l]    <= mem_pc_d[l];
                mem_cause_q[l] <= mem_cause_d[l];
            end
        end
    end

endmodule

// File: tb/tb_exc_word_gen.sv
// Directed bench for exc_word_gen: instruction-level reference model checked
// every cycle, plus hand-computed expectations at key points.
module tb_exc_word_gen;

  logic        clk = 1'b0;
  logic        reset, stall, ext_flush;
  logic        id_valid_1, id_valid_2, id_ds_1, id_ds_2;
  logic [31:0] id_pc_1, id_pc_2;
  logic        id_if_adel_1, id_if_adel_2, id_ri_1, id_ri_2, id_break_1, id_break_2;
  logic        id_syscall_1, id_syscall_2, id_eret_1, id_eret_2;
  logic        ex_ov_1, ex_ov_2, mem_adel_1, mem_adel_2, mem_ades_1, mem_ades_2;
  logic [31:0] mem_vaddr_1, mem_vaddr_2;

  exc_word_gen_if cp0_bus ();

  exc_word_gen dut (
    .clk(clk), .reset(reset), .stall(stall), .ext_flush(ext_flush),
    .id_valid_1(id_valid_1), .id_valid_2(id_valid_2),
    .id_pc_1(id_pc_1), .id_pc_2(id_pc_2), .id_ds_1(id_ds_1), .id_ds_2(id_ds_2),
    .id_if_adel_1(id_if_adel_1), .id_if_adel_2(id_if_adel_2),
    .id_ri_1(id_ri_1), .id_ri_2(id_ri_2),
    .id_break_1(id_break_1), .id_break_2(id_break_2),
    .id_syscall_1(id_syscall_1), .id_syscall_2(id_syscall_2),
    .id_eret_1(id_eret_1), .id_eret_2(id_eret_2),
    .ex_ov_1(ex_ov_1), .ex_ov_2(ex_ov_2),
    .mem_adel_1(mem_adel_1), .mem_adel_2(mem_adel_2),
    .mem_ades_1(mem_ades_1), .mem_ades_2(mem_ades_2),
    .mem_vaddr_1(mem_vaddr_1), .mem_vaddr_2(mem_vaddr_2),
    .cp0(cp0_bus)
  );

  // clock
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit started  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [1:0][15:0] word;
    logic [1:0][31:0] pc;
    logic [1:0][31:0] vaddr;
    logic             flush;
  } exp_t;

  bit          m_ex_v [2];
  bit          m_ex_ds [2];
  logic [31:0] m_ex_pc [2];
  logic [7:0]  m_ex_c [2];
  bit          m_mem_v [2];
  bit          m_mem_ds [2];
  logic [31:0] m_mem_pc [2];
  logic [7:0]  m_mem_c [2];

  function automatic logic [7:0] id_causes(input int l);
    logic [7:0] c;
    c = 8'h00;
    if (l == 0) begin
      if (!id_valid_1) return 8'h00;
      c[0] = id_if_adel_1; c[1] = id_ri_1; c[3] = id_break_1; c[4] = id_syscall_1; c[6] = id_eret_1;
    end else begin
      if (!id_valid_2) return 8'h00;
      c[0] = id_if_adel_2; c[1] = id_ri_2; c[3] = id_break_2; c[4] = id_syscall_2; c[6] = id_eret_2;
    end
    return c;
  endfunction

  function automatic exp_t model_out();
    exp_t       e;
    logic [7:0] raw, c;
    int         order [8] = '{0, 1, 3, 4, 6, 2, 5, 7};
    logic       adel, ades;
    logic [31:0] va;
    e = '0;
    for (int l = 0; l < 2; l++) begin
      adel = (l == 0) ? mem_adel_1 : mem_adel_2;
      ades = (l == 0) ? mem_ades_1 : mem_ades_2;
      va   = (l == 0) ? mem_vaddr_1 : mem_vaddr_2;
      raw  = 8'h00;
      if (m_mem_v[l]) begin
        raw = m_mem_c[l];
        if (adel) raw = raw | 8'h20;
        if (ades) raw = raw | 8'h80;
      end
      c = 8'h00;
      for (int k = 0; k < 8; k++)
        if (c == 8'h00 && raw[order[k]]) c[order[k]] = 1'b1;
      if (c != 8'h00) e.word[l] = 16'h8000 | (m_mem_ds[l] ? 16'h0100 : 16'h0000) | {8'h00, c};
      e.pc[l] = m_mem_v[l] ? m_mem_pc[l] : 32'h0;
      if (c == 8'h20 || c == 8'h80) e.vaddr[l] = va;
      else if (c == 8'h01)          e.vaddr[l] = m_mem_pc[l];
    end
    if (e.word[0][15]) e.word[1] = 16'h0000;
    e.flush = e.word[0][15] | e.word[1][15];
    return e;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int l = 0; l < 2; l++) begin
        m_ex_v[l] <= 1'b0; m_ex_ds[l] <= 1'b0; m_ex_pc[l] <= 32'h0; m_ex_c[l] <= 8'h00;
        m_mem_v[l] <= 1'b0; m_mem_ds[l] <= 1'b0; m_mem_pc[l] <= 32'h0; m_mem_c[l] <= 8'h00;
      end
    end else if (model_out().flush || ext_flush) begin
      for (int l = 0; l < 2; l++) begin
        m_ex_v[l] <= 1'b0; m_ex_c[l] <= 8'h00; m_mem_v[l] <= 1'b0; m_mem_c[l] <= 8'h00;
      end
    end else if (!stall) begin
      for (int l = 0; l < 2; l++) begin
        m_mem_v[l]  <= m_ex_v[l];
        m_mem_ds[l] <= m_ex_ds[l];
        m_mem_pc[l] <= m_ex_pc[l];
        m_mem_c[l]  <= m_ex_c[l] | ((m_ex_v[l] && ((l == 0) ? ex_ov_1 : ex_ov_2)) ? 8'h04 : 8'h00);
        m_ex_v[l]   <= (l == 0) ? id_valid_1 : id_valid_2;
        m_ex_ds[l]  <= (l == 0) ? id_ds_1 : id_ds_2;
        m_ex_pc[l]  <= (l == 0) ? id_pc_1 : id_pc_2;
        m_ex_c[l]   <= id_causes(l);
      end
    end
  end

  // ---------------- scoreboard: every cycle ----------------
  always @(negedge clk) begin
    if (started) begin
      exp_t e;
      e = model_out();
      chk("word_1",  {16'h0, cp0_bus.exc_word_1}, {16'h0, e.word[0]});
      chk("word_2",  {16'h0, cp0_bus.exc_word_2}, {16'h0, e.word[1]});
      chk("pc_1",    cp0_bus.exc_pc_1, e.pc[0]);
      chk("pc_2",    cp0_bus.exc_pc_2, e.pc[1]);
      chk("vaddr_1", cp0_bus.exc_vaddr_1, e.vaddr[0]);
      chk("vaddr_2", cp0_bus.exc_vaddr_2, e.vaddr[1]);
      chk("flush",   {31'h0, cp0_bus.exc_flush}, {31'h0, e.flush});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle();
    stall = 0; ext_flush = 0;
    id_valid_1 = 0; id_valid_2 = 0; id_pc_1 = 0; id_pc_2 = 0; id_ds_1 = 0; id_ds_2 = 0;
    id_if_adel_1 = 0; id_if_adel_2 = 0; id_ri_1 = 0; id_ri_2 = 0;
    id_break_1 = 0; id_break_2 = 0; id_syscall_1 = 0; id_syscall_2 = 0;
    id_eret_1 = 0; id_eret_2 = 0; ex_ov_1 = 0; ex_ov_2 = 0;
    mem_adel_1 = 0; mem_adel_2 = 0; mem_ades_1 = 0; mem_ades_2 = 0;
    mem_vaddr_1 = 0; mem_vaddr_2 = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_w1"}, {16'h0, cp0_bus.exc_word_1}, 32'h0);
    chk({tag, "_w2"}, {16'h0, cp0_bus.exc_word_2}, 32'h0);
    chk({tag, "_pc1"}, cp0_bus.exc_pc_1, 32'h0);
    chk({tag, "_pc2"}, cp0_bus.exc_pc_2, 32'h0);
    chk({tag, "_va1"}, cp0_bus.exc_vaddr_1, 32'h0);
    chk({tag, "_va2"}, cp0_bus.exc_vaddr_2, 32'h0);
    chk({tag, "_fl"}, {31'h0, cp0_bus.exc_flush}, 32'h0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    exp_t e;
    idle();
    reset = 1;
    step();
    started = 1'b1;
    step();
    reset = 0;
    chk_all_zero("reset");

    // lane 1 syscall
    id_valid_1 = 1; id_syscall_1 = 1; id_pc_1 = 32'hBFC0_0100;
    step(); idle();
    step();
    e = model_out();
    chk("sys_model_w1", {16'h0, e.word[0]}, 32'h8010);
    chk("sys_w1", {16'h0, cp0_bus.exc_word_1}, 32'h8010);
    chk("sys_pc1", cp0_bus.exc_pc_1, 32'hBFC0_0100);
    chk("sys_flush", {31'h0, cp0_bus.exc_flush}, 32'h1);
    step();
    chk("sys_after_w1", {16'h0, cp0_bus.exc_word_1}, 32'h0);

    // both lanes fault in the same ID cycle
    id_valid_1 = 1; id_ri_1 = 1; id_pc_1 = 32'h0040_0000;
    id_valid_2 = 1; id_break_2 = 1; id_pc_2 = 32'h0040_0004;
    step(); idle();
    step();
    chk("both_w1", {16'h0, cp0_bus.exc_word_1}, 32'h8002);
    chk("both_w2", {16'h0, cp0_bus.exc_word_2}, 32'h0);
    step();

    // lane 2 store error, with a younger lane-1 syscall sitting in EX
    id_valid_2 = 1; id_ds_2 = 1; id_pc_2 = 32'h0040_0010;
    step(); idle();
    id_valid_1 = 1; id_syscall_1 = 1; id_pc_1 = 32'h0040_0020;
    step(); idle();
    mem_ades_2 = 1; mem_vaddr_2 = 32'h8000_0003;
    #1;
    e = model_out();
    chk("ades_model_w2", {16'h0, e.word[1]}, 32'h8180);
    chk("ades_w2", {16'h0, cp0_bus.exc_word_2}, 32'h8180);
    chk("ades_va2", cp0_bus.exc_vaddr_2, 32'h8000_0003);
    chk("ades_pc2", cp0_bus.exc_pc_2, 32'h0040_0010);
    chk("ades_flush", {31'h0, cp0_bus.exc_flush}, 32'h1);
    step(); idle();
    chk("ades_next_w1", {16'h0, cp0_bus.exc_word_1}, 32'h0);
    step();
    chk("ades_ex1_cleared", {16'h0, cp0_bus.exc_word_1}, 32'h0);

    // priority: IF adel beats OV and MEM adel
    id_valid_1 = 1; id_if_adel_1 = 1; id_pc_1 = 32'hFFFF_FFFC;
    step(); idle();
    ex_ov_1 = 1;
    step(); idle();
    mem_adel_1 = 1; mem_vaddr_1 = 32'h1234_5678;
    #1;
    e = model_out();
    chk("prio_model_va1", e.vaddr[0], 32'hFFFF_FFFC);
    chk("prio_w1", {16'h0, cp0_bus.exc_word_1}, 32'h8001);
    chk("prio_va1", cp0_bus.exc_vaddr_1, 32'hFFFF_FFFC);
    chk("prio_pc1", cp0_bus.exc_pc_1, 32'hFFFF_FFFC);
    step(); idle();

    // EX overflow on lane 2 with PC 0
    id_valid_2 = 1; id_pc_2 = 32'h0;
    step(); idle();
    ex_ov_2 = 1;
    step(); idle();
    chk("ov_w2", {16'h0, cp0_bus.exc_word_2}, 32'h8004);
    chk("ov_pc2", cp0_bus.exc_pc_2, 32'h0);
    chk("ov_va2", cp0_bus.exc_vaddr_2, 32'h0);
    step();

    // causes without id_valid are ignored
    id_syscall_1 = 1; id_pc_1 = 32'h0040_0100;
    step(); idle();
    step();
    chk("novalid_w1", {16'h0, cp0_bus.exc_word_1}, 32'h0);
    chk("novalid_fl", {31'h0, cp0_bus.exc_flush}, 32'h0);

    // stall with eret held in EX, then stall together with the flush
    id_valid_1 = 1; id_eret_1 = 1; id_pc_1 = 32'h8000_0180;
    step(); idle();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_w1", {16'h0, cp0_bus.exc_word_1}, 32'h0);
    end
    stall = 0;
    step();
    chk("eret_w1", {16'h0, cp0_bus.exc_word_1}, 32'h8040);
    chk("eret_flush", {31'h0, cp0_bus.exc_flush}, 32'h1);
    stall = 1;
    step();
    chk("stallflush_w1", {16'h0, cp0_bus.exc_word_1}, 32'h0);
    chk("stallflush_pc1", cp0_bus.exc_pc_1, 32'h0);
    stall = 0;
    step();

    // external flush drops an EX-stage syscall
    id_valid_1 = 1; id_syscall_1 = 1; id_pc_1 = 32'h0040_0200;
    step(); idle();
    ext_flush = 1;
    step(); idle();
    step();
    chk("extflush_w1", {16'h0, cp0_bus.exc_word_1}, 32'h0);

    // reset mid-flight: break in MEM, syscall in EX
    id_valid_1 = 1; id_break_1 = 1; id_pc_1 = 32'h0040_0300;
    step(); idle();
    id_valid_2 = 1; id_syscall_2 = 1; id_pc_2 = 32'h0040_0304;
    step(); idle();
    chk("pre_reset_w1", {16'h0, cp0_bus.exc_word_1}, 32'h8008);
    reset = 1;
    step();
    reset = 0;
    chk_all_zero("rst1");
    step();
    chk_all_zero("rst2");
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
